// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives the combinational ROM and buffers
// {pc, inst} pairs so decode stalls do not stop fetching; keeps one branch delay slot.
module if_fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter int          DEPTH_LOG2 = 2,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        id_ready_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [31:0]           pc_q, pc_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [31:0]           pc_mem_q   [DEPTH];
    logic [31:0]           inst_mem_q [DEPTH];

    logic pop, issue, enq, flush;

    // Head handshake: an entry leaves when if_valid_o and id_ready_i are both high in
    // the same cycle; the ROM is fetched whenever a slot is free or is being freed.
    assign if_valid_o = !rst && (count_q != '0);
    assign pop        = if_valid_o && id_ready_i;
    assign issue      = !rst && ((count_q < FULL_CNT) || pop);
    assign rom_ce_o   = issue;
    assign rom_addr_o = rst ? RESET_PC : pc_q;
    assign if_pc_o    = if_valid_o ? pc_mem_q[rd_ptr_q]   : 32'h0;
    assign if_inst_o  = if_valid_o ? inst_mem_q[rd_ptr_q] : 32'h0;

    // A redirect drops everything behind the delay slot; the slot is either popping now,
    // already at the head, or (empty queue) is this cycle's fetch.
    assign flush = branch_flag_i && (pop || (count_q != '0));
    assign enq   = issue && !flush;

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + {{DEPTH_LOG2{1'b0}}, enq} - {{DEPTH_LOG2{1'b0}}, pop};
        if (issue) pc_d = pc_q + 32'd4;
        if (enq)   wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (branch_flag_i) begin
            pc_d = branch_target_i;
            if (flush) begin
                wr_ptr_d = rd_ptr_q + PTR_ONE;
                count_d  = pop ? '0 : CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            inst_mem_q[wr_ptr_q] <= rom_inst_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed fetch/stall/redirect/reset sequences, popped head
// entries checked against a queue of hand-computed {pc, inst} pairs.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        id_ready = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;

    logic        w_rst = 1'b1;
    logic        w_ce;
    logic [31:0] w_addr, w_inst_in;
    logic        w_ready = 1'b0;
    logic        w_valid;
    logic [31:0] w_pc, w_inst;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp2_q[$];

    always #5 clk = ~clk;

    // ROM image: word i holds 0x1000 + i
    assign rom_inst  = 32'h1000 + (rom_addr >> 2);
    assign w_inst_in = 32'h1000 + (w_addr >> 2);

    if_fetch_queue u_dut (
        .clk(clk), .rst(rst), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
        .id_ready_i(id_ready), .branch_flag_i(branch_flag), .branch_target_i(branch_target),
        .if_valid_o(if_valid), .if_pc_o(if_pc), .if_inst_o(if_inst)
    );

    if_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(w_rst), .rom_ce_o(w_ce), .rom_addr_o(w_addr), .rom_inst_i(w_inst_in),
        .id_ready_i(w_ready), .branch_flag_i(1'b0), .branch_target_i(32'h0),
        .if_valid_o(w_valid), .if_pc_o(w_pc), .if_inst_o(w_inst)
    );

    // Monitors: every accepted head entry must match the oldest expected pair
    always @(negedge clk) begin
        if (if_valid && id_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc=%h inst=%h, expected none", if_pc, if_inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({if_pc, if_inst} !== e) begin
                    errors++;
                    $display("FAIL pop: got pc=%h inst=%h, expected pc=%h inst=%h",
                             if_pc, if_inst, e[63:32], e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (w_valid && w_ready) begin
            checks++;
            if (exp2_q.size() == 0) begin
                errors++;
                $display("FAIL wrap_pop_unexpected: got pc=%h inst=%h, expected none", w_pc, w_inst);
            end else begin
                logic [63:0] e;
                e = exp2_q.pop_front();
                if ({w_pc, w_inst} !== e) begin
                    errors++;
                    $display("FAIL wrap_pop: got pc=%h inst=%h, expected pc=%h inst=%h",
                             w_pc, w_inst, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    // Covers the sampling edge of the current cycle, then advances one cycle
    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            pos();
        end
    endtask

    task automatic do_reset(input int n, input logic rdy);
        rst = 1'b1;
        id_ready = rdy;
        branch_flag = 1'b0;
        @(negedge clk);
        chk("rst_ce", {31'b0, rom_ce}, 32'h0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        pos();
        repeat (n - 1) pos();
        rst = 1'b0;
    endtask

    initial begin
        pos();
        // T1: free run from reset
        for (int i = 0; i < 6; i++) push(32'(i * 4), 32'h1000 + 32'(i));
        do_reset(3, 1'b1);
        @(negedge clk);
        chk("t1_c0_ce", {31'b0, rom_ce}, 32'h1);
        chk("t1_c0_addr", rom_addr, 32'h0);
        chk("t1_c0_valid", {31'b0, if_valid}, 32'h0);
        pos();
        @(negedge clk);
        chk("t1_c1_addr", rom_addr, 32'h4);
        chk("t1_c1_valid", {31'b0, if_valid}, 32'h1);
        pos();
        run_cycles(5);

        // T2: stall until full, then release
        push(32'h0, 32'h1000); push(32'h4, 32'h1001); push(32'h8, 32'h1002);
        push(32'hC, 32'h1003); push(32'h10, 32'h1004);
        do_reset(2, 1'b0);
        run_cycles(4);
        for (int c = 4; c < 6; c++) begin
            @(negedge clk);
            chk("t2_full_ce", {31'b0, rom_ce}, 32'h0);
            chk("t2_full_addr", rom_addr, 32'h10);
            chk("t2_full_head", if_pc, 32'h0);
            pos();
        end
        id_ready = 1'b1;
        @(negedge clk);
        chk("t2_release_ce", {31'b0, rom_ce}, 32'h1);
        pos();
        run_cycles(4);

        // T3: redirect while the delay slot pops, queue {8,C,10}
        push(32'h0, 32'h1000); push(32'h4, 32'h1001); push(32'h8, 32'h1002);
        push(32'h40, 32'h1010); push(32'h44, 32'h1011);
        do_reset(2, 1'b0);
        run_cycles(3);
        id_ready = 1'b1;
        run_cycles(2);
        branch_flag = 1'b1;
        branch_target = 32'h40;
        @(negedge clk);
        chk("t3_slot_head", if_pc, 32'h8);
        pos();
        branch_flag = 1'b0;
        @(negedge clk);
        chk("t3_addr", rom_addr, 32'h40);
        chk("t3_valid", {31'b0, if_valid}, 32'h0);
        pos();
        run_cycles(2);

        // T4: redirect while stalled, queue {8,C}
        push(32'h0, 32'h1000); push(32'h4, 32'h1001); push(32'h8, 32'h1002);
        push(32'h40, 32'h1010); push(32'h44, 32'h1011);
        do_reset(2, 1'b0);
        run_cycles(2);
        id_ready = 1'b1;
        run_cycles(2);
        id_ready = 1'b0;
        branch_flag = 1'b1;
        branch_target = 32'h40;
        pos();
        branch_flag = 1'b0;
        @(negedge clk);
        chk("t4_kept_valid", {31'b0, if_valid}, 32'h1);
        chk("t4_kept_pc", if_pc, 32'h8);
        chk("t4_addr", rom_addr, 32'h40);
        pos();
        id_ready = 1'b1;
        run_cycles(3);

        // T4b: redirect on an empty queue with pc = 8
        push(32'h0, 32'h1000); push(32'h8, 32'h1002);
        push(32'h40, 32'h1010); push(32'h44, 32'h1011);
        do_reset(2, 1'b0);
        run_cycles(1);
        id_ready = 1'b1;
        branch_flag = 1'b1;
        branch_target = 32'h8;
        run_cycles(1);
        id_ready = 1'b0;
        branch_target = 32'h40;
        @(negedge clk);
        chk("t4b_empty", {31'b0, if_valid}, 32'h0);
        chk("t4b_addr", rom_addr, 32'h8);
        pos();
        branch_flag = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        chk("t4b_slot_pc", if_pc, 32'h8);
        chk("t4b_slot_inst", if_inst, 32'h1002);
        chk("t4b_addr_target", rom_addr, 32'h40);
        pos();
        run_cycles(2);

        // T5b: one reset cycle with three entries queued
        push(32'h0, 32'h1000); push(32'h4, 32'h1001);
        do_reset(2, 1'b0);
        run_cycles(3);
        do_reset(1, 1'b0);
        id_ready = 1'b1;
        @(negedge clk);
        chk("t5b_valid", {31'b0, if_valid}, 32'h0);
        chk("t5b_addr", rom_addr, 32'h0);
        chk("t5b_ce", {31'b0, rom_ce}, 32'h1);
        pos();
        run_cycles(2);
        rst = 1'b1;

        // T5: PC wrap with RESET_PC = 0xFFFF_FFF8
        exp2_q.push_back({32'hFFFF_FFF8, 32'h4000_0FFE});
        exp2_q.push_back({32'hFFFF_FFFC, 32'h4000_0FFF});
        exp2_q.push_back({32'h0000_0000, 32'h0000_1000});
        exp2_q.push_back({32'h0000_0004, 32'h0000_1001});
        w_ready = 1'b1;
        @(negedge clk);
        chk("t5_rst_addr", w_addr, 32'hFFFF_FFF8);
        chk("t5_rst_ce", {31'b0, w_ce}, 32'h0);
        pos();
        w_rst = 1'b0;
        @(negedge clk);
        chk("t5_c0_addr", w_addr, 32'hFFFF_FFF8);
        pos();
        run_cycles(1);
        @(negedge clk);
        chk("t5_c2_addr", w_addr, 32'h0);
        pos();
        run_cycles(2);
        w_ready = 1'b0;
        pos();

        chk("drain_main", 32'(exp_q.size()), 32'h0);
        chk("drain_wrap", 32'(exp2_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
